divider_iter: RTL and testbench

DIVIDER_ITER -- requirements
Module: divider_iter

---
 rtl/divider_iter.sv | 125 ++++++++++++
 tb/tb_divider_iter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/divider_iter.sv
// divider_iter -- iterative 32-bit integer divider (radix-2 restoring).
// Performs DIV / DIVU / REM / REMU, one quotient bit per cycle (32 cycles).
// A zero divisor or signed overflow skips the iteration and completes in one cycle.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   in_valid/in_ready  request handshake; op/dividend/divisor are sampled on accept
//   flush              synchronous kill of any in-flight or completed operation
//   out_valid/out_ready result handshake; result is 0 whenever out_valid is low
module divider_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [31:0] quot, rem, dsor;
    logic        sel_rem, neg_res;

    // Request decode: sign handling and the two bypass cases
    logic        signed_op, a_neg, b_neg, by_zero, ovf, accept;
    logic [31:0] a_mag, b_mag;

    always_comb begin
        signed_op = ~op[0];
        a_neg     = signed_op & dividend[31];
        b_neg     = signed_op & divisor[31];
        a_mag     = a_neg ? (32'd0 - dividend) : dividend;
        b_mag     = b_neg ? (32'd0 - divisor)  : divisor;
        by_zero   = (divisor == 32'd0);
        ovf       = signed_op && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);
        accept    = in_valid && (state == IDLE) && !flush;
    end

    // One restoring step: shift {rem,quot} left, trial-subtract on the upper 33 bits
    logic [32:0] shifted;
    logic [33:0] diff;
    logic        ge;
    logic [31:0] rem_step, quot_step;

    always_comb begin
        shifted   = {rem, quot[31]};
        diff      = {1'b0, shifted} - {2'b00, dsor};
        ge        = ~diff[33];
        // Either branch fits in 32 bits: the kept value is always below the divisor
        rem_step  = ge ? diff[31:0] : shifted[31:0];
        quot_step = {quot[30:0], ge};
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM: next state (flush outranks accept and out_ready)
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nxt = (by_zero || ovf) ? DONE : CALC;
                CALC:    if (cnt == 5'd31) state_nxt = DONE;
                DONE:    if (out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // FSM: outputs, decoded from registered state only
    logic [31:0] mag;
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        mag       = sel_rem ? rem : quot;
        result    = out_valid ? (neg_res ? (32'd0 - mag) : mag) : 32'd0;
    end

    // Datapath. Bypass cases preload quot/rem with the final answer and clear
    // neg_res so the common output path yields it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= 5'd0;
            quot    <= 32'd0;
            rem     <= 32'd0;
            dsor    <= 32'd0;
            sel_rem <= 1'b0;
            neg_res <= 1'b0;
        end else if (accept) begin
            cnt     <= 5'd0;
            sel_rem <= op[1];
            dsor    <= b_mag;
            if (by_zero) begin
                quot    <= 32'hFFFF_FFFF;
                rem     <= dividend;
                neg_res <= 1'b0;
            end else if (ovf) begin
                quot    <= 32'h8000_0000;
                rem     <= 32'd0;
                neg_res <= 1'b0;
            end else begin
                quot    <= a_mag;
                rem     <= 32'd0;
                // remainder follows dividend sign; quotient negative iff signs differ
                neg_res <= op[1] ? a_neg : (a_neg ^ b_neg);
            end
        end else if (state == CALC) begin
            quot <= quot_step;
            rem  <= rem_step;
            cnt  <= cnt + 5'd1;
        end
    end

endmodule

// File: tb/tb_divider_iter.sv
module tb_divider_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  op = 2'd0;
    logic [31:0] dividend = 32'd0;
    logic [31:0] divisor = 32'd0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    logic [31:0] expq[$];

    divider_iter dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .dividend(dividend), .divisor(divisor), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a result is consumed
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got 0x%08h expected no output", result);
            end else begin
                logic [31:0] e;
                e = expq.pop_front();
                if (result !== e) begin
                    errors++;
                    $display("FAIL result: got 0x%08h expected 0x%08h", result, e);
                end
            end
        end
    end

    // Reference model using the simulator's own arithmetic
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic ov;
        ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            2'd0:    model = (b == 0) ? 32'hFFFF_FFFF : ov ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            2'd1:    model = (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'd2:    model = (b == 0) ? a : ov ? 32'd0 : 32'($signed(a) % $signed(b));
            default: model = (b == 0) ? a : a % b;
        endcase
    endfunction

    // Called at posedge+1; the request is accepted on the following edge
    task automatic send(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit push, input logic [31:0] e);
        int g;
        g = 0;
        while (!in_ready && g < 100) begin @(posedge clk); #1; g++; end
        if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1; op = o; dividend = a; divisor = b;
        if (push) expq.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0; dividend = $urandom; divisor = $urandom;
    endtask

    // Edges after the accept edge until out_valid is seen (bounded)
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        if (!out_valid) chk("valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e, input int exp_lat, input string name);
        int lat;
        send(o, a, b, 1'b1, e);
        wait_valid(lat);
        if (exp_lat >= 0) chk(name, 32'(lat), 32'(exp_lat));
        @(posedge clk); #1;
    endtask

    initial begin
        int lat, seen;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        // Reset state before any clock edge
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;

        // Basic ops with latency: 32 edges after accept for iterative, 0 for bypass
        run(2'd1, 32'd100, 32'd7, 32'd14, 32, "lat_divu");
        run(2'd3, 32'd100, 32'd7, 32'd2, 32, "lat_remu");
        run(2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, -1, "");
        run(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, -1, "");
        run(2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, -1, "");
        run(2'd1, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, "lat_div0");
        run(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, "lat_ovf");
        run(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, "lat_ovf_div");
        run(2'd2, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 0, "lat_rem0");

        // Back-pressure: result held, in_ready low while stalled
        out_ready = 1'b0;
        send(2'd1, 32'd9, 32'd3, 1'b1, 32'd3);
        wait_valid(lat);
        for (int i = 0; i < 10; i++) begin
            chk("stall_result", result, 32'd3);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("after_pop_in_ready", 32'(in_ready), 32'd1);
        chk("after_pop_out_valid", 32'(out_valid), 32'd0);
        chk("after_pop_result", result, 32'd0);

        // Flush at step 10 with a competing request in the same cycle
        send(2'd1, 32'd1000, 32'd3, 1'b0, 32'd0);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1; in_valid = 1'b1; op = 2'd1; dividend = 32'd50; divisor = 32'd5;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        chk("flush_no_output", 32'(seen), 32'd0);
        run(2'd1, 32'd1, 32'd1, 32'd1, 32, "post_flush_lat");

        // Asynchronous reset between edges mid-calculation
        send(2'd0, 32'd12345, 32'd17, 1'b0, 32'd0);
        repeat (5) @(posedge clk);
        #2; rst = 1'b1;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_result", result, 32'd0);
        @(posedge clk); #2; rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        chk("arst_no_output", 32'(seen), 32'd0);

        // Randomised compare against the model, corner operands mixed in
        for (int i = 0; i < 60; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case (i % 10)
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 20));
                3: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
                default: ;
            endcase
            run(ro, ra, rb, model(ro, ra, rb), -1, "");
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 32'(expq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
